// File: rtl/systola_pe_os.sv
// Output-stationary MAC processing element with operand forwarding and a one-entry
// ready/valid result buffer that also passes results from the upstream chain.
module systola_pe_os #(
  parameter int DW     = 8,
  parameter int AW     = 32,
  parameter int SIGNED = 0,
  parameter int SAT    = 0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          fire,
  input  logic [DW-1:0] in_w,
  input  logic [DW-1:0] in_a,
  input  logic          in_last,
  output logic          out_f,
  output logic [DW-1:0] out_w,
  output logic [DW-1:0] out_a,
  output logic          out_last,
  input  logic [AW-1:0] res_in,
  input  logic          res_in_valid,
  output logic          res_in_ready,
  output logic [AW-1:0] res_out,
  output logic          res_out_valid,
  input  logic          res_out_ready,
  output logic          ovf_err,
  output logic          sat_flag
);

  localparam bit SGN = (SIGNED != 0);
  localparam bit SAT_EN = (SAT != 0);
  localparam int XW = AW + 1 - 2*DW;

  logic [2*DW-1:0] w_ext;
  logic [2*DW-1:0] a_ext;
  logic [2*DW-1:0] prod;
  logic [AW:0]     prod_ext;
  logic [AW:0]     acc_ext;
  logic [AW:0]     sum_full;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   clamp;
  logic [AW-1:0]   sum;
  logic            ovf;
  logic            sat_hit;
  logic            complete;
  logic            pop;
  logic            space;
  logic            chain_load;

  // The low 2*DW bits of a product are the same for signed and unsigned operands
  // once both are extended to 2*DW, so one multiplier serves both modes.
  assign w_ext = SGN ? {{DW{in_w[DW-1]}}, in_w} : {{DW{1'b0}}, in_w};
  assign a_ext = SGN ? {{DW{in_a[DW-1]}}, in_a} : {{DW{1'b0}}, in_a};
  assign prod  = w_ext * a_ext;

  assign prod_ext = {{XW{SGN & prod[2*DW-1]}}, prod};
  assign acc_ext  = {SGN & acc[AW-1], acc};
  assign sum_full = acc_ext + prod_ext;

  assign ovf   = SGN ? (sum_full[AW] ^ sum_full[AW-1]) : sum_full[AW];
  assign clamp = SGN ? {sum_full[AW], {(AW-1){~sum_full[AW]}}} : {AW{1'b1}};
  assign sum   = (SAT_EN && ovf) ? clamp : sum_full[AW-1:0];
  assign sat_hit = SAT_EN & fire & ovf;

  assign complete     = fire & in_last;
  assign pop          = res_out_valid & res_out_ready;
  assign space        = ~res_out_valid | pop;
  assign res_in_ready = space & ~complete;
  assign chain_load   = res_in_valid & res_in_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_f    <= 1'b0;
      out_last <= 1'b0;
      out_w    <= '0;
      out_a    <= '0;
    end else begin
      out_f    <= fire;
      out_last <= complete;
      if (fire) begin
        out_w <= in_w;
        out_a <= in_a;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc      <= '0;
      sat_flag <= 1'b0;
    end else begin
      if (fire) acc <= in_last ? '0 : sum;
      if (sat_hit) sat_flag <= 1'b1;
    end
  end

  // A local completion wins the buffer; if the buffer cannot take it the sum is lost.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res_out       <= '0;
      res_out_valid <= 1'b0;
      ovf_err       <= 1'b0;
    end else if (complete) begin
      if (space) begin
        res_out       <= sum;
        res_out_valid <= 1'b1;
      end else begin
        ovf_err <= 1'b1;
      end
    end else if (chain_load) begin
      res_out       <= res_in;
      res_out_valid <= 1'b1;
    end else if (pop) begin
      res_out_valid <= 1'b0;
    end
  end

endmodule
